// File: rtl/timer_run_ctrl.sv
// ---------------------------------------------------------------------------
// timer_run_ctrl_debounce
//   Per-button input path: 2-FF synchronizer, stable-sample debouncer and a
//   registered one-cycle press pulse on each accepted 0->1 transition.
//
//   clk    in  system clock
//   rst    in  asynchronous active-low reset
//   btn    in  raw active-high button, asynchronous to clk
//   press  out one-cycle pulse per accepted press (releases give nothing)
// ---------------------------------------------------------------------------
module timer_run_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;      // sync[1] is the synchronized sample
    logic [1:0]    sync_vld;  // marks when sync[1] holds a real button sample
    logic [CW-1:0] cnt;
    logic          level;     // accepted (debounced) level
    logic          level_d;
    logic          armed;     // button has been seen released since reset

    // NOTE: every register here uses non-blocking assignment so all of them
    // sample the pre-edge values of each other, exactly like the hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync     <= '0;
            sync_vld <= '0;
            cnt      <= '0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], btn};
            sync_vld <= {sync_vld[0], 1'b1};
            level_d  <= level;

            // A button held through reset must not yield a press: pulses are
            // only allowed once a genuine low sample has been observed.
            if (sync_vld[1] && !sync[1])
                armed <= 1'b1;

            press <= level & ~level_d & armed;

            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// timer_run_ctrl
//   Stopwatch control sequencer: debounces the start/stop and reset/lap
//   buttons and runs an IDLE/RUN/PAUSE/LAP/FULL state machine that drives the
//   mm:ss counter with a one-second enable, a clear pulse and a display hold.
//
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   btn_ss    in  raw start/stop button
//   btn_rl    in  raw reset/lap button
//   at_max    in  datapath is at 59:59 (looked at only on tick cycles)
//   count_en  out one-cycle pulse: advance the counter by one second
//   clr       out one-cycle pulse: zero the counter
//   hold      out freeze the displayed value (LAP)
//   running   out high in RUN and LAP
//   state     out IDLE=0, RUN=1, PAUSE=2, LAP=3, FULL=4
// ---------------------------------------------------------------------------
module timer_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_rl,
    input  logic       at_max,
    output logic       count_en,
    output logic       clr,
    output logic       hold,
    output logic       running,
    output logic [2:0] state
);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic          ss_press, rl_press;
    logic          active, tick;
    logic          nxt_ce, nxt_clr;
    logic [TW-1:0] tick_cnt;

    timer_run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk(clk), .rst(rst), .btn(btn_ss), .press(ss_press)
    );
    timer_run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rl (
        .clk(clk), .rst(rst), .btn(btn_rl), .press(rl_press)
    );

    assign active = (cur == S_RUN) || (cur == S_LAP);
    assign tick   = active && (tick_cnt == TW'(TICK_DIV - 1));
    assign state  = cur;

    // Next-state and pulse decode. ss beats rl; a tick that saturates beats
    // any press.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        nxt     = cur;
        nxt_ce  = 1'b0;
        nxt_clr = 1'b0;
        case (cur)
            S_IDLE: begin
                if (ss_press)
                    nxt = S_RUN;
                else if (rl_press)
                    nxt_clr = 1'b1;
            end
            S_RUN, S_LAP: begin
                if (tick && at_max) begin
                    nxt = S_FULL;
                end else begin
                    nxt_ce = tick;
                    if (ss_press)
                        nxt = S_PAUSE;
                    else if (rl_press)
                        nxt = (cur == S_RUN) ? S_LAP : S_RUN;
                end
            end
            S_PAUSE: begin
                if (ss_press) begin
                    nxt = S_RUN;
                end else if (rl_press) begin
                    nxt     = S_IDLE;
                    nxt_clr = 1'b1;
                end
            end
            S_FULL: begin
                if (rl_press) begin
                    nxt     = S_IDLE;
                    nxt_clr = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= S_IDLE;
            tick_cnt <= '0;
            count_en <= 1'b0;
            clr      <= 1'b0;
            hold     <= 1'b0;
            running  <= 1'b0;
        end else begin
            cur      <= nxt;
            count_en <= nxt_ce;
            clr      <= nxt_clr;
            hold     <= (nxt == S_LAP);
            running  <= (nxt == S_RUN) || (nxt == S_LAP);

            // Sub-second phase: reset when stopped, frozen in PAUSE so a
            // resume continues the interrupted second.
            if (cur == S_IDLE || cur == S_FULL)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= '0;
            else if (active)
                tick_cnt <= tick_cnt + TW'(1);
        end
    end
endmodule

// File: tb/tb_timer_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_run_ctrl
//   Directed bench for timer_run_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=10.
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_timer_run_ctrl;
    localparam int DB  = 4;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss, btn_rl, at_max;
    logic       count_en, clr, hold, running;
    logic [2:0] state;

    int n_vec    = 0;
    int n_err    = 0;
    int ce_cnt   = 0;  // count_en pulses seen so far
    int both_cnt = 0;  // cycles with clr and count_en high together

    timer_run_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_rl(btn_rl),
        .at_max(at_max), .count_en(count_en), .clr(clr), .hold(hold),
        .running(running), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land just after it.
    task automatic step();
        @(posedge clk);
        #1;
        if (count_en) ce_cnt++;
        if (count_en && clr) both_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Hold the button(s) long enough to be accepted; returns just after the
    // edge where the FSM reacts (raw high sampled at E, FSM edge E+3+DB).
    task automatic press(input logic ss, input logic rl);
        btn_ss = ss;
        btn_rl = rl;
        repeat (DB + 3) step();
        btn_ss = 1'b0;
        btn_rl = 1'b0;
        step();
    endtask

    initial begin
        int ce0, ce1, found;

        rst = 1'b0; btn_ss = 1'b0; btn_rl = 1'b0; at_max = 1'b0;
        #23 rst = 1'b1;
        #3;
        check("rst_state",    state,    0);
        check("rst_count_en", count_en, 0);
        check("rst_clr",      clr,      0);
        check("rst_hold",     hold,     0);
        check("rst_running",  running,  0);
        idle(5);

        // rl in IDLE: clear pulse, stay IDLE
        press(1'b0, 1'b1);
        check("idle_rl_clr",   clr,   1);
        check("idle_rl_state", state, 0);
        step();
        check("idle_rl_clr_end", clr, 0);
        idle(6);

        // ss held from edge E: state changes exactly at E+7
        btn_ss = 1'b1;
        idle(7);
        check("start_before", state, 0);
        step();
        check("start_state",   state,   1);
        check("start_running", running, 1);
        btn_ss = 1'b0;
        // first count_en TICK_DIV cycles after entering RUN, then every 10
        idle(9);
        check("ce1_early", count_en, 0);
        step();
        check("ce1", count_en, 1);
        idle(9);
        check("ce2_early", count_en, 0);
        step();
        check("ce2", count_en, 1);

        // pause 6 cycles after a count_en, hold 50 cycles, resume
        ce0 = ce_cnt;
        idle(8);
        press(1'b1, 1'b0);
        check("pause_state",   state,         2);
        check("pause_running", running,       0);
        check("pause_ce_seen", ce_cnt - ce0,  1);
        ce1 = ce_cnt;
        idle(50);
        press(1'b1, 1'b0);
        check("resume_state",  state,         1);
        check("pause_no_ce",   ce_cnt - ce1,  0);
        idle(3);
        check("resume_ce_early", count_en, 0);
        step();
        check("resume_ce", count_en, 1);

        // lap
        idle(6);
        press(1'b0, 1'b1);
        check("lap_state",   state,   3);
        check("lap_hold",    hold,    1);
        check("lap_running", running, 1);
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            step();
            if (count_en) found = 1;
        end
        check("lap_ce", found, 1);
        check("lap_hold_kept", hold, 1);
        idle(6);
        press(1'b0, 1'b1);
        check("unlap_state", state, 1);
        check("unlap_hold",  hold,  0);
        idle(6);
        press(1'b0, 1'b1);
        check("lap2_state", state, 3);
        idle(6);
        press(1'b1, 1'b0);
        check("lap_pause_state", state, 2);
        check("lap_pause_hold",  hold,  0);

        // saturation
        idle(6);
        press(1'b1, 1'b0);
        check("sat_run", state, 1);
        at_max = 1'b1;
        ce0 = ce_cnt;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            step();
            if (state == 3'd4) found = 1;
        end
        check("full_reached", found,        1);
        check("full_ce",      count_en,     0);
        check("full_no_ce",   ce_cnt - ce0, 0);
        check("full_running", running,      0);
        idle(6);
        press(1'b1, 1'b0);
        check("full_ss_ignored", state, 4);
        idle(6);
        press(1'b0, 1'b1);
        check("full_rl_state", state, 0);
        check("full_rl_clr",   clr,   1);
        at_max = 1'b0;
        idle(6);

        // glitch rejection: 1..3 cycle pulses ignored
        for (int w = 1; w <= 3; w++) begin
            btn_ss = 1'b1;
            idle(w);
            btn_ss = 1'b0;
            idle(12);
            check($sformatf("glitch_%0d", w), state, 0);
        end
        // 4-cycle pulse accepted
        btn_ss = 1'b1;
        idle(4);
        btn_ss = 1'b0;
        idle(3);
        check("pulse4_before", state, 0);
        step();
        check("pulse4_state", state, 1);

        // back to IDLE, then both buttons together
        idle(6);
        press(1'b1, 1'b0);
        check("to_pause", state, 2);
        idle(6);
        press(1'b0, 1'b1);
        check("pause_rl_state", state, 0);
        check("pause_rl_clr",   clr,   1);
        idle(6);
        press(1'b1, 1'b1);
        check("both_state", state, 1);
        check("both_clr",   clr,   0);

        // reset mid-LAP with ss held
        idle(6);
        press(1'b0, 1'b1);
        check("lap3_state", state, 3);
        idle(6);
        btn_ss = 1'b1;
        idle(3);
        rst = 1'b0;
        #1;
        check("arst_state",    state,    0);
        check("arst_hold",     hold,     0);
        check("arst_running",  running,  0);
        check("arst_count_en", count_en, 0);
        check("arst_clr",      clr,      0);
        idle(2);
        #2 rst = 1'b1;
        idle(30);
        check("held_no_press", state, 0);
        btn_ss = 1'b0;
        idle(12);
        check("held_release", state, 0);
        press(1'b1, 1'b0);
        check("after_reset_ss", state, 1);

        check("clr_ce_overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/timer_run_ctrl.md
# timer_run_ctrl

Control sequencer for the mm:ss stopwatch datapath. It takes two raw push-buttons (start/stop and reset/lap) and debounces them. A run/pause/lap/full state machine then drives the time-keeping counter with a one-cycle seconds enable, a synchronous clear and a display-hold flag. It sits between the board buttons and the time manager/BCD/seven-segment chain, and replaces direct button wiring and the free-running divided clock with a single-clock-domain enable scheme.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required before a button level is accepted (≥2).
- TICK_DIV, 100000000: clk cycles per counted second (≥2).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Clears all state while 0.
- btn_ss  in  1  raw start/stop button, active-high, asynchronous to clk.
- btn_rl  in  1  raw reset/lap button, active-high, asynchronous to clk.
- at_max  in  1  datapath reports 59:59 held, sampled only on tick cycles.
- count_en  out  1  one-cycle pulse: advance the time counter by one second.
- clr  out  1  one-cycle pulse: zero the time counter.
- hold  out  1  freeze displayed value (lap view); the counter keeps running.
- running  out  1  high in RUN and LAP.
- state  out  3  current state: IDLE=0, RUN=1, PAUSE=2, LAP=3, FULL=4.

## Operation
- Button path, per button:
  - 2-FF synchronizer, then debouncer.
  - Debounce counter increments while the synchronized sample differs from the accepted level and clears to 0 on any equal sample.
  - The accepted level toggles when the counter reaches DEBOUNCE_CYCLES.
  - A registered press pulse (one cycle) fires on each accepted 0→1 transition. Releases produce no pulse.
- Tick generator:
  - Counter 0..TICK_DIV-1, width clog2(TICK_DIV).
  - Increments only in RUN/LAP.
  - Holds its value in PAUSE, so a resume keeps the sub-second phase.
  - Forced to 0 in IDLE and FULL.
  - A tick occurs in the cycle where the counter equals TICK_DIV-1 and the state is RUN or LAP. The counter wraps to 0.
- State transitions (ss = start/stop press, rl = reset/lap press):
  - IDLE: ss→RUN; rl→IDLE with clr pulse.
  - RUN: ss→PAUSE; rl→LAP; tick & at_max→FULL; tick & !at_max→count_en pulse.
  - LAP: ss→PAUSE; rl→RUN; tick handling identical to RUN.
  - PAUSE: ss→RUN; rl→IDLE with clr pulse.
  - FULL: ss ignored; rl→IDLE with clr pulse.
- Simultaneous ss and rl in one cycle: ss wins, rl is discarded.
- Press coinciding with tick:
  - The tick is still honoured (count_en or →FULL).
  - If the tick causes →FULL, the press is discarded.
  - Otherwise the press transition applies.
- Outputs:
  - hold=1 exactly while state==LAP.
  - running=1 in RUN/LAP.
  - count_en is never asserted on the tick that enters FULL.
- Reset (rst=0, any time including mid-count or mid-debounce):
  - state=IDLE; count_en=0, clr=0, hold=0, running=0.
  - Tick counter, debounce counters, accepted levels and synchronizers all 0.
  - No press pulse is generated by reset release, even if a button is held. The accepted level starts at 0, so a held button is accepted only after DEBOUNCE_CYCLES stable samples.

## Timing
- All outputs are registered; no combinational input→output path.
- Button latency: raw input high and stable from edge E yields the accepted level at edge E+1+DEBOUNCE_CYCLES and the press pulse at edge E+2+DEBOUNCE_CYCLES.
- FSM/output response: edge E+3+DEBOUNCE_CYCLES, when state, hold and running update and the clr pulse asserts.
- Glitches shorter than DEBOUNCE_CYCLES clk cycles (after synchronization) produce no press.
- First count_en after IDLE→RUN occurs TICK_DIV cycles after the state becomes RUN. Subsequent pulses follow every TICK_DIV cycles in RUN/LAP.
- clr and count_en are never high in the same cycle.

## Test plan
- With DEBOUNCE_CYCLES=4 and TICK_DIV=10: press ss from reset. Required: state 0→1 at edge 7; count_en at 10-cycle spacing; running=1.
- Glitch rejection: btn_ss pulses of 1–3 cycles. Required: no state change. A 4-cycle-stable pulse is accepted.
- Pause/resume phase: pause 6 cycles after a count_en, wait 50 cycles, resume. Required: next count_en 4 cycles after re-entering RUN; no count_en during PAUSE.
- Lap: in RUN press rl. Required: state=3 and hold=1 while count_en keeps pulsing; rl again gives state=1, hold=0; ss in LAP gives PAUSE with hold=0.
- Saturation: at_max=1 at a tick. Required: state=4, count_en=0 that cycle, running=0; ss ignored; rl gives clr pulse and state=0.
- Both buttons pressed together in IDLE gives RUN with no clr. Asserting rst mid-LAP with btn_ss held clears all outputs to 0. After release, the held button is accepted after debounce with no press pulse, and state stays IDLE.
